// File: rtl/eeprom_boot_loader.sv
// Boot loader: copies WORD_COUNT big-endian words from the serial EEPROM reader into RAM, then serves CPU byte reads.
// Optional image checksum enabled with `define EEPROM_BOOT_CHECKSUM_EN.
module eeprom_boot_loader #(
  parameter int unsigned WORD_COUNT   = 1024,
  parameter int unsigned EEPROM_START = 0,
  parameter int unsigned RAM_BASE     = 0
) (
  input  logic        raw_clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [10:0] eeprom_address,
  output logic        eeprom_strobe,
  input  logic        eeprom_ready,
  input  logic [7:0]  eeprom_data,
  output logic [10:0] mem_address,
  output logic [15:0] mem_data,
  output logic        mem_write,
  input  logic        cpu_request,
  input  logic [10:0] cpu_address,
  output logic [7:0]  cpu_data,
  output logic        cpu_ready,
  output logic        boot_done,
  output logic        busy,
  output logic        checksum_error
);

  localparam logic [10:0] START_A = 11'(EEPROM_START);
  localparam logic [10:0] BASE_A  = 11'(RAM_BASE);
  localparam logic [10:0] LAST_I  = 11'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_REQ, S_WAIT_BUSY, S_WAIT_DONE, S_WRITE, S_DONE
  } state_t;

  // Which client owns the current byte transaction.
  typedef enum logic [1:0] {O_HI, O_LO, O_CPU} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [10:0] addr_q, addr_d;
  logic [10:0] idx_q, idx_d;
  logic [10:0] maddr_q, maddr_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  cdata_q, cdata_d;
  logic        cready_q, cready_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_SYNC;
      owner_q  <= O_HI;
      addr_q   <= '0;
      idx_q    <= '0;
      maddr_q  <= '0;
      word_q   <= '0;
      cdata_q  <= '0;
      cready_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      maddr_q  <= maddr_d;
      word_q   <= word_d;
      cdata_q  <= cdata_d;
      cready_q <= cready_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    maddr_d  = maddr_q;
    word_d   = word_q;
    cdata_d  = cdata_q;
    cready_d = 1'b0;
    done_d   = done_q;
    busy_d   = busy_q;
    case (state_q)
      S_SYNC: begin
        if (eeprom_ready) begin
          state_d = S_REQ;
          owner_d = O_HI;
          addr_d  = START_A;
          idx_d   = '0;
        end
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          owner_d = O_HI;
          addr_d  = START_A;
          idx_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (cpu_request && done_q && !cready_q) begin
          // The request still seen during the cpu_ready cycle belongs to the finished read.
          state_d = S_REQ;
          owner_d = O_CPU;
          addr_d  = cpu_address;
          busy_d  = 1'b1;
        end
      end
      S_REQ: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!eeprom_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (eeprom_ready) begin
          case (owner_q)
            O_HI: begin
              word_d[15:8] = eeprom_data;
              owner_d      = O_LO;
              addr_d       = addr_q + 11'd1;
              state_d      = S_REQ;
            end
            O_LO: begin
              word_d[7:0] = eeprom_data;
              maddr_d     = BASE_A + idx_q;
              state_d     = S_WRITE;
            end
            default: begin
              cdata_d  = eeprom_data;
              cready_d = 1'b1;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end
          endcase
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 11'd1;
        if (idx_q == LAST_I) begin
          state_d = S_DONE;
        end else begin
          // addr_q sits on the low byte of word i, so +1 is the high byte of word i+1.
          owner_d = O_HI;
          addr_d  = addr_q + 11'd1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_SYNC;
    endcase
  end

`ifdef EEPROM_BOOT_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        err_q, err_d;

  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (state_q == S_IDLE && start) begin
      sum_d = '0;
      err_d = 1'b0;
    end else if (state_q == S_WRITE) begin
      sum_d = sum_q + word_q;
    end else if (state_q == S_DONE) begin
      err_d = (sum_q != 16'h0000);
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign checksum_error = err_q;
`else
  assign checksum_error = 1'b0;
`endif

  assign eeprom_address = addr_q;
  assign eeprom_strobe  = (state_q == S_REQ);
  assign mem_address    = maddr_q;
  assign mem_data       = word_q;
  assign mem_write      = (state_q == S_WRITE);
  assign cpu_data       = cdata_q;
  assign cpu_ready      = cready_q;
  assign boot_done      = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_eeprom_boot_loader.sv
// Scoreboard bench for eeprom_boot_loader with a behavioural EEPROM byte reader (WORD_COUNT=2).
module tb_eeprom_boot_loader;

  logic        raw_clk;
  logic        reset_n;
  logic        start;
  logic [10:0] eeprom_address;
  logic        eeprom_strobe;
  logic        eeprom_ready;
  logic [7:0]  eeprom_data;
  logic [10:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_write;
  logic        cpu_request;
  logic [10:0] cpu_address;
  logic [7:0]  cpu_data;
  logic        cpu_ready;
  logic        boot_done;
  logic        busy;
  logic        checksum_error;

  eeprom_boot_loader #(
    .WORD_COUNT  (2),
    .EEPROM_START(0),
    .RAM_BASE    (0)
  ) dut (
    .raw_clk       (raw_clk),
    .reset_n       (reset_n),
    .start         (start),
    .eeprom_address(eeprom_address),
    .eeprom_strobe (eeprom_strobe),
    .eeprom_ready  (eeprom_ready),
    .eeprom_data   (eeprom_data),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .mem_write     (mem_write),
    .cpu_request   (cpu_request),
    .cpu_address   (cpu_address),
    .cpu_data      (cpu_data),
    .cpu_ready     (cpu_ready),
    .boot_done     (boot_done),
    .busy          (busy),
    .checksum_error(checksum_error)
  );

  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  // Reader model: no reset, ready drops the cycle after a strobe, data valid 4 cycles later.
  logic [7:0]  emem [0:2047];
  logic        rdy = 1'b1;
  logic [7:0]  edata = 8'h00;
  logic [10:0] laddr = 11'h000;
  int          lat = 0;

  always @(posedge raw_clk) begin
    if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        rdy   <= 1'b1;
        edata <= emem[laddr];
      end
    end else if (eeprom_strobe) begin
      rdy   <= 1'b0;
      laddr <= eeprom_address;
      lat   <= 4;
    end
  end

  assign eeprom_ready = rdy;
  assign eeprom_data  = edata;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int cpu_cnt = 0;
  logic [10:0] last_saddr = '0;
  logic [26:0] wq [$];
  logic [7:0]  cq [$];

  task automatic monitor();
    logic [26:0] ew;
    logic [7:0]  ec;
    forever begin
      @(posedge raw_clk);
      #1;
      if (reset_n) begin
        if (eeprom_strobe) begin
          strobe_cnt++;
          last_saddr = eeprom_address;
          total++;
          if (lat != 0 || !rdy) begin
            bad++;
            $display("FAIL strobe_while_busy: ready=%0b lat=%0d required idle reader", rdy, lat);
          end
        end
        if (mem_write) begin
          total++;
          if (wq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: addr=%h data=%h required no write", mem_address, mem_data);
          end else begin
            ew = wq.pop_front();
            if ({mem_address, mem_data} !== ew) begin
              bad++;
              $display("FAIL ram_write: got addr=%h data=%h required addr=%h data=%h",
                       mem_address, mem_data, ew[26:16], ew[15:0]);
            end
          end
        end
        if (cpu_ready) begin
          cpu_cnt++;
          total++;
          if (cq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cpu_ready: data=%h required no pulse", cpu_data);
          end else begin
            ec = cq.pop_front();
            if (cpu_data !== ec) begin
              bad++;
              $display("FAIL cpu_data: got %h required %h", cpu_data, ec);
            end
          end
          total++;
          if (wq.size() != 0 || boot_done !== 1'b1) begin
            bad++;
            $display("FAIL cpu_before_boot: pending_writes=%0d boot_done=%b required 0 and 1",
                     wq.size(), boot_done);
          end
        end
      end
    end
  endtask

  task automatic wait_boot_done(input string tag);
    for (int k = 0; k < 300 && !boot_done; k++) @(negedge raw_clk);
    total++;
    if (boot_done !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: boot_done=%b required 1", tag, boot_done);
    end
  endtask

  task automatic wait_cpu(input int target, input string tag);
    for (int k = 0; k < 300 && cpu_cnt < target; k++) @(negedge raw_clk);
    total++;
    if (cpu_cnt != target) begin
      bad++;
      $display("FAIL %s_cpu_timeout: ready_pulses=%0d required %0d", tag, cpu_cnt, target);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge raw_clk);
    start = 1'b0;
  endtask

  task automatic push_image(input logic [15:0] w0, input logic [15:0] w1);
    wq.push_back({11'h000, w0});
    wq.push_back({11'h001, w1});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_request = 1'b1;
    cpu_address = 11'h005;
    repeat (3) @(negedge raw_clk);
    total++;
    if ({eeprom_address, eeprom_strobe, mem_address, mem_data, mem_write, cpu_data,
         cpu_ready, boot_done, busy, checksum_error} !== {11'h0, 1'b0, 11'h0, 16'h0, 1'b0,
         8'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: addr=%h stb=%b maddr=%h mdata=%h mw=%b cdata=%h crdy=%b done=%b busy=%b err=%b required all 0 with busy=1",
               eeprom_address, eeprom_strobe, mem_address, mem_data, mem_write, cpu_data,
               cpu_ready, boot_done, busy, checksum_error);
    end
  endtask

  task automatic test_boot_held_cpu();
    push_image(16'h1234, 16'h5678);
    cq.push_back(8'hA5);
    reset_n = 1'b1;
    wait_boot_done("boot");
    total++;
    if (strobe_cnt != 4 || cpu_cnt != 0 || wq.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL boot_summary: strobes=%0d cpu=%0d pending=%0d busy=%b required 4 0 0 0",
               strobe_cnt, cpu_cnt, wq.size(), busy);
    end
    wait_cpu(1, "held");
    cpu_request = 1'b0;
    repeat (10) @(negedge raw_clk);
    total++;
    if (cpu_cnt != 1 || strobe_cnt != 5 || last_saddr !== 11'h005) begin
      bad++;
      $display("FAIL held_cpu_read: pulses=%0d strobes=%0d addr=%h required 1 5 005",
               cpu_cnt, strobe_cnt, last_saddr);
    end
  endtask

  task automatic test_cpu_read();
    int s0;
    s0 = strobe_cnt;
    cq.push_back(8'h3C);
    cpu_request = 1'b1;
    cpu_address = 11'h123;
    @(negedge raw_clk);
    cpu_address = 11'h7FF;
    wait_cpu(2, "cpu_read");
    cpu_request = 1'b0;
    repeat (5) @(negedge raw_clk);
    total++;
    if (strobe_cnt != s0 + 1 || last_saddr !== 11'h123 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cpu_addr_latch: strobes=%0d addr=%h busy=%b required %0d 123 0",
               strobe_cnt - s0, last_saddr, busy, 1);
    end
  endtask

  task automatic test_start_and_cpu();
    int s0;
    s0 = strobe_cnt;
    push_image(16'h1234, 16'h5678);
    cq.push_back(8'hA5);
    cpu_request = 1'b1;
    cpu_address = 11'h005;
    pulse_start();
    total++;
    if (boot_done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_priority: boot_done=%b busy=%b required 0 1", boot_done, busy);
    end
    wait_cpu(3, "start_cpu");
    cpu_request = 1'b0;
    repeat (5) @(negedge raw_clk);
    total++;
    if (strobe_cnt != s0 + 5) begin
      bad++;
      $display("FAIL start_cpu_strobes: got %0d required 5", strobe_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    push_image(16'h1234, 16'h5678);
    pulse_start();
    for (int k = 0; k < 50 && rdy; k++) @(negedge raw_clk);
    total++;
    if (rdy !== 1'b0) begin
      bad++;
      $display("FAIL mid_txn_timeout: ready=%b required 0", rdy);
    end
    reset_n = 1'b0;
    @(negedge raw_clk);
    reset_n = 1'b1;
    s0 = strobe_cnt;
    for (int k = 0; k < 50 && strobe_cnt == s0; k++) @(negedge raw_clk);
    total++;
    if (strobe_cnt != s0 + 1 || last_saddr !== 11'h000) begin
      bad++;
      $display("FAIL restart_addr: strobes=%0d addr=%h required 1 000", strobe_cnt - s0, last_saddr);
    end
    pulse_start();
    wait_boot_done("reset_mid");
    repeat (20) @(negedge raw_clk);
    total++;
    if (wq.size() != 0 || strobe_cnt != s0 + 4) begin
      bad++;
      $display("FAIL reset_mid_reload: pending=%0d strobes=%0d required 0 4", wq.size(), strobe_cnt - s0);
    end
  endtask

  task automatic test_checksum();
    logic exp_err;
`ifdef EEPROM_BOOT_CHECKSUM_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    emem[2] = 8'hED;
    emem[3] = 8'hCC;
    push_image(16'h1234, 16'hEDCC);
    pulse_start();
    wait_boot_done("csum_good");
    total++;
    if (checksum_error !== 1'b0 || wq.size() != 0) begin
      bad++;
      $display("FAIL checksum_good: err=%b pending=%0d required 0 0", checksum_error, wq.size());
    end
    emem[3] = 8'hCD;
    push_image(16'h1234, 16'hEDCD);
    pulse_start();
    wait_boot_done("csum_bad");
    total++;
    if (checksum_error !== exp_err || boot_done !== 1'b1 || wq.size() != 0) begin
      bad++;
      $display("FAIL checksum_bad: err=%b done=%b pending=%0d required %b 1 0",
               checksum_error, boot_done, wq.size(), exp_err);
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) emem[a] = 8'(a * 7 + 3);
    emem[0] = 8'h12;
    emem[1] = 8'h34;
    emem[2] = 8'h56;
    emem[3] = 8'h78;
    emem[5] = 8'hA5;
    emem[11'h123] = 8'h3C;
    reset_n = 1'b0;
    start = 1'b0;
    cpu_request = 1'b0;
    cpu_address = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_boot_held_cpu();
    test_cpu_read();
    test_start_and_cpu();
    test_reset_mid();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eeprom_boot_loader.md
Name: eeprom_boot_loader

Overview:
- Sequences the serial EEPROM byte reader. After reset it copies a boot image from EEPROM into core RAM as 16-bit words, then hands the reader over to the CPU for single-byte reads.
- Sits between the EEPROM reader (address/strobe/ready/data_out handshake), the RAM write port, and the CPU I/O channel.
- The loader has absolute priority over the CPU until boot_done is set.

Parameters:
- WORD_COUNT, 1024: number of 16-bit words to copy. Each word is 2 EEPROM bytes; EEPROM_START + 2*WORD_COUNT must be <= 2048.
- EEPROM_START, 0: first EEPROM byte address of the image.
- RAM_BASE, 0: first RAM word address written.

Ports:
- raw_clk  in  1  system clock (12 MHz)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; re-runs the boot copy
- eeprom_address  out  11  byte address to the reader
- eeprom_strobe  out  1  one-cycle read request to the reader
- eeprom_ready  in  1  reader idle / data valid
- eeprom_data  in  8  byte from the reader
- mem_address  out  11  RAM word address
- mem_data  out  16  RAM write data
- mem_write  out  1  one-cycle RAM write enable
- cpu_request  in  1  CPU byte read request, level, held until cpu_ready
- cpu_address  in  11  CPU byte address
- cpu_data  out  8  byte returned to the CPU
- cpu_ready  out  1  one-cycle pulse, cpu_data valid
- boot_done  out  1  image copied; CPU access enabled
- busy  out  1  reader transaction or copy in progress
- checksum_error  out  1  see Optional Feature

Behaviour:
- Reset values: all outputs 0 except busy=1. Entry state is SYNC.
- The reader has no reset. A reset mid-transaction therefore lands in SYNC, which waits for eeprom_ready==1 before any strobe is issued.

Byte transaction (shared by the loader and the CPU):
- REQ: drive eeprom_address and pulse eeprom_strobe for 1 cycle. Hold eeprom_address stable until DONE.
- WAIT_BUSY: wait for eeprom_ready==0. The reader drops ready one cycle after the strobe.
- WAIT_DONE: wait for eeprom_ready==1, then capture eeprom_data in that same cycle.

State machine and transitions:
- SYNC -> LOAD_HI once eeprom_ready==1.
- LOAD_HI: byte at EEPROM_START+2*i is captured into mem_data[15:8].
- LOAD_LO: byte at EEPROM_START+2*i+1 is captured into mem_data[7:0] (big-endian).
- WRITE: mem_address=RAM_BASE+i, mem_write=1 for exactly 1 cycle. Then i increments.
  - If i==WORD_COUNT-1 -> DONE, else -> LOAD_HI.
- DONE: set boot_done=1 and busy=0 -> IDLE.
- IDLE:
  - start==1 -> clear boot_done, i=0, busy=1 -> LOAD_HI.
  - else if cpu_request && boot_done -> CPU byte transaction with cpu_address.
  - start wins if it coincides with cpu_request.
- CPU completion: cpu_data=eeprom_data, cpu_ready=1 for 1 cycle, busy=0 -> IDLE.
  - The next cpu_request is sampled no earlier than the cycle after cpu_ready.
  - cpu_address is latched at REQ, so later changes are ignored.

Ignored and blocked inputs:
- start during any non-IDLE state is ignored. There is no queueing.
- cpu_request while boot_done==0 is never serviced and cpu_ready stays 0.

Arithmetic and limits:
- Index i is 11 bits. Address sums wrap mod 2048; the parameter check above forbids reaching the wrap.
- mem_write is never asserted outside WRITE.
- eeprom_strobe is never asserted unless the previous transaction has completed.

Optional Feature:
- EEPROM_BOOT_CHECKSUM_EN defined:
  - A 16-bit modulo-2^16 sum accumulates all WORD_COUNT words as written.
  - At DONE, checksum_error = (sum != 16'h0000). The image's last word is the two's-complement balance.
  - The sum clears on start and on reset.
  - boot_done is set regardless of the checksum result.
- Not defined: no sum logic; checksum_error is tied to 0.

Test Plan:
- Reset, EEPROM model holds bytes 0x12,0x34,0x56,0x78 at 0..3, WORD_COUNT=2 -> exactly two writes: RAM[0]=16'h1234 then RAM[1]=16'h5678. boot_done=1 after the second write; 4 strobes total.
- After boot, cpu_request=1 with cpu_address=11'h005 (byte 0xA5) -> one strobe with eeprom_address=0x005, then one cpu_ready pulse with cpu_data=8'hA5.
- cpu_request held high from reset -> no CPU strobe before boot_done. Service occurs only after the last write; cpu_ready pulses once per request.
- start and cpu_request asserted in the same IDLE cycle -> reload runs first (boot_done drops to 0). The CPU is served after the reload's DONE.
- Assert reset_n=0 while the reader is mid-transaction (eeprom_ready=0) -> no strobe until eeprom_ready returns 1. Reload restarts at EEPROM_START and all RAM words end up correct.
- With EEPROM_BOOT_CHECKSUM_EN and words 16'h1234, 16'hEDCC -> checksum_error=0. Corrupting the last byte to 0xCD -> checksum_error=1 and boot_done=1.
